rr_dff_arbiter: RTL and testbench

- Round-robin arbiter that shares one DW-bit registered storage element (a D-flip-flop bank: reset-to-0, capture-on-posedge) between N_REQ requesters.
- Grants one requester at a time and captures the granted requester's data into the shared register each cycle.
- Bounds each grant to MAX_HOLD beats for fairness.
- Sits between multiple producers and the single shared flop bank in the verification-training datapath.

---
 rtl/rr_dff_arbiter.sv | 156 +++++++++++++++
 tb/tb_rr_dff_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_dff_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_dff_arbiter
// Brief    : Round-robin arbiter sharing one DW-bit register among N_REQ
//            requesters, with each grant bounded to MAX_HOLD capture beats.
//            Optional macro ARB_LOCK_EN adds a lock input that suppresses the
//            hold-limit release.
// Revision : 1.0 - initial release
// ============================================================================
module rr_dff_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      din,
`ifdef ARB_LOCK_EN
  input  logic                     lock,
`endif
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [DW-1:0]            dout,
  output logic                     dout_valid
);

  localparam int c_idx_w  = $clog2(N_REQ);
  localparam int c_hold_w = $clog2(MAX_HOLD + 1);
  localparam logic [c_hold_w-1:0] c_max_hold = c_hold_w'(MAX_HOLD);
  localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state, w_state;
  logic [c_idx_w-1:0]   r_ptr, w_ptr;
  logic [c_idx_w-1:0]   r_owner, w_owner;
  logic [c_hold_w-1:0]  r_hold, w_hold;
  logic [N_REQ-1:0]     r_gnt, w_gnt;
  logic [DW-1:0]        r_dout, w_dout;
  logic                 r_dv, w_dv;

  logic [N_REQ-1:0]     w_owner_oh;
  logic [N_REQ-1:0]     w_others;
  logic [c_idx_w-1:0]   w_owner_inc;
  logic [c_idx_w-1:0]   w_win_idle;
  logic [c_idx_w-1:0]   w_win_others;
  logic                 w_own_req;
  logic                 w_expired;

  // First set bit scanning upward from start, wrapping modulo N_REQ.
  function automatic logic [c_idx_w-1:0] f_winner(input logic [N_REQ-1:0] r,
                                                  input logic [c_idx_w-1:0] start);
    logic [c_idx_w-1:0] idx;
    logic               found;
    f_winner = start;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = c_idx_w'((int'(start) + k) % N_REQ);
      if (!found && r[idx]) begin
        f_winner = idx;
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [N_REQ-1:0] f_onehot(input logic [c_idx_w-1:0] idx);
    f_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign w_owner_oh   = f_onehot(r_owner);
  assign w_others     = req & ~w_owner_oh;
  assign w_own_req    = req[r_owner];
  assign w_owner_inc  = (r_owner == c_idx_w'(N_REQ - 1)) ? '0 : r_owner + c_idx_w'(1);
  assign w_win_idle   = f_winner(req, r_ptr);
  assign w_win_others = f_winner(w_others, w_owner_inc);
`ifdef ARB_LOCK_EN
  assign w_expired    = (r_hold == c_max_hold) && !lock;
`else
  assign w_expired    = (r_hold == c_max_hold);
`endif

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_hold  = r_hold;
    w_gnt   = r_gnt;
    w_dout  = r_dout;
    w_dv    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner = w_win_idle;
          w_gnt   = f_onehot(w_win_idle);
          w_hold  = c_hold_one;
          w_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_own_req) begin
          w_dout = din[r_owner*DW +: DW];
          w_dv   = 1'b1;
        end
        if (!w_own_req || w_expired) begin
          w_ptr = w_owner_inc;
          if (|w_others) begin
            w_owner = w_win_others;
            w_gnt   = f_onehot(w_win_others);
            w_hold  = c_hold_one;
          end else if (w_own_req) begin
            w_hold  = c_hold_one;
          end else begin
            w_gnt   = '0;
            w_state = S_IDLE;
          end
        end else if (r_hold != c_max_hold) begin
          // Saturation only matters when lock holds the grant past MAX_HOLD.
          w_hold = r_hold + c_hold_one;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_hold  <= w_hold;
      r_gnt   <= w_gnt;
      r_dout  <= w_dout;
      r_dv    <= w_dv;
    end
  end

  assign gnt        = r_gnt;
  assign owner      = r_owner;
  assign dout       = r_dout;
  assign dout_valid = r_dv;

endmodule
`default_nettype wire

// File: tb/tb_rr_dff_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rr_dff_arbiter
// Brief    : Scenario bench for rr_dff_arbiter (N_REQ=4, DW=8, MAX_HOLD=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_dff_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        lock_i;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  dout;
  logic        dout_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] req;
    logic       lock;
    logic [3:0] gnt;
    logic [1:0] own;
    logic [7:0] dout;
    logic       dv;
  } step_t;

  step_t plan[$];
  step_t sb[$];

  rr_dff_arbiter #(.N_REQ(4), .DW(8), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
`ifdef ARB_LOCK_EN
    .lock       (lock_i),
`endif
    .gnt        (gnt),
    .owner      (owner),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(input logic [3:0] r, input logic l, input logic [3:0] g,
                               input logic [7:0] d, input logic v);
    step_t s;
    s.req = r; s.lock = l; s.gnt = g; s.dout = d; s.dv = v; s.own = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) s.own = 2'(i);
    return s;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t s, e;
    req = 4'($urandom_range(1, 15));
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, dout, dout_valid, owner} !== 15'd0)
      begin n_fail++; $display("FAIL reset_async: gnt=%b dout=%h dv=%b owner=%0d required all 0", gnt, dout, dout_valid, owner); end
    req = 4'b0000;
    #1 rst = 1'b0;
    repeat (3) plan.push_back(mk(4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0));
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid} !== {e.gnt, e.dout, e.dv})
        begin n_fail++; $display("FAIL reset_idle: gnt=%b dout=%h dv=%b required gnt=%b dout=%h dv=%b", gnt, dout, dout_valid, e.gnt, e.dout, e.dv); end
    end
  endtask

  task automatic test_single();
    step_t s, e;
    do_reset();
    din = {8'h00, 8'h00, 8'h00, 8'hA5};
    plan.push_back(mk(4'b0001, 1'b0, 4'b0001, 8'h00, 1'b0));
    repeat (11) plan.push_back(mk(4'b0001, 1'b0, 4'b0001, 8'hA5, 1'b1));
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid} !== {e.gnt, e.dout, e.dv})
        begin n_fail++; $display("FAIL single: gnt=%b dout=%h dv=%b required gnt=%b dout=%h dv=%b", gnt, dout, dout_valid, e.gnt, e.dout, e.dv); end
      if (e.gnt != 4'b0000) begin
        n_checks++;
        if (owner !== e.own) begin n_fail++; $display("FAIL single_owner: owner=%0d required %0d", owner, e.own); end
      end
    end
  endtask

  task automatic test_round_robin();
    step_t s, e;
    logic [7:0] d;
    do_reset();
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    // Four beats per owner, regrant on the release edge, capture lags grant by one edge.
    for (int k = 1; k <= 21; k++) begin
      d = (k == 1) ? 8'h00 : 8'h10 + 8'(((k - 2) / 4) % 4);
      plan.push_back(mk(4'b1111, 1'b0, 4'b0001 << (((k - 1) / 4) % 4), d, k > 1));
    end
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid} !== {e.gnt, e.dout, e.dv})
        begin n_fail++; $display("FAIL round_robin: gnt=%b dout=%h dv=%b required gnt=%b dout=%h dv=%b", gnt, dout, dout_valid, e.gnt, e.dout, e.dv); end
      n_checks++;
      if (owner !== e.own) begin n_fail++; $display("FAIL round_robin_owner: owner=%0d required %0d", owner, e.own); end
    end
  endtask

  task automatic test_early_drop();
    step_t s, e;
    do_reset();
    din = {8'h00, 8'h00, 8'hC3, 8'h3C};
    plan.push_back(mk(4'b0011, 1'b0, 4'b0001, 8'h00, 1'b0));
    plan.push_back(mk(4'b0011, 1'b0, 4'b0001, 8'h3C, 1'b1));
    plan.push_back(mk(4'b0011, 1'b0, 4'b0001, 8'h3C, 1'b1));
    plan.push_back(mk(4'b0010, 1'b0, 4'b0010, 8'h3C, 1'b0));
    repeat (6) plan.push_back(mk(4'b0010, 1'b0, 4'b0010, 8'hC3, 1'b1));
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid} !== {e.gnt, e.dout, e.dv})
        begin n_fail++; $display("FAIL early_drop: gnt=%b dout=%h dv=%b required gnt=%b dout=%h dv=%b", gnt, dout, dout_valid, e.gnt, e.dout, e.dv); end
      n_checks++;
      if (owner !== e.own) begin n_fail++; $display("FAIL early_drop_owner: owner=%0d required %0d", owner, e.own); end
    end
  endtask

  task automatic test_reset_mid_busy();
    step_t s, e;
    do_reset();
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    // Owner 1 drops immediately so owner 2 wins with ptr advanced to 2.
    plan.push_back(mk(4'b0010, 1'b0, 4'b0010, 8'h00, 1'b0));
    plan.push_back(mk(4'b0100, 1'b0, 4'b0100, 8'h00, 1'b0));
    plan.push_back(mk(4'b0100, 1'b0, 4'b0100, 8'h12, 1'b1));
    plan.push_back(mk(4'b0100, 1'b0, 4'b0100, 8'h12, 1'b1));
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid} !== {e.gnt, e.dout, e.dv})
        begin n_fail++; $display("FAIL mid_busy_pre: gnt=%b dout=%h dv=%b required gnt=%b dout=%h dv=%b", gnt, dout, dout_valid, e.gnt, e.dout, e.dv); end
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, dout, dout_valid} !== 13'd0)
      begin n_fail++; $display("FAIL mid_busy_reset: gnt=%b dout=%h dv=%b required all 0", gnt, dout, dout_valid); end
    req = 4'b1111;
    #1 rst = 1'b0;
    plan.push_back(mk(4'b1111, 1'b0, 4'b0001, 8'h00, 1'b0));
    plan.push_back(mk(4'b1111, 1'b0, 4'b0001, 8'h10, 1'b1));
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid, owner} !== {e.gnt, e.dout, e.dv, e.own})
        begin n_fail++; $display("FAIL mid_busy_ptr: gnt=%b dout=%h dv=%b owner=%0d required gnt=%b dout=%h dv=%b owner=%0d", gnt, dout, dout_valid, owner, e.gnt, e.dout, e.dv, e.own); end
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    step_t s, e;
    do_reset();
    din = {8'h00, 8'h00, 8'h5B, 8'hB5};
    plan.push_back(mk(4'b0011, 1'b1, 4'b0001, 8'h00, 1'b0));
    repeat (12) plan.push_back(mk(4'b0011, 1'b1, 4'b0001, 8'hB5, 1'b1));
    plan.push_back(mk(4'b0011, 1'b0, 4'b0010, 8'hB5, 1'b1));
    plan.push_back(mk(4'b0011, 1'b0, 4'b0010, 8'h5B, 1'b1));
    while (plan.size() > 0) begin
      s = plan.pop_front(); req = s.req; lock_i = s.lock; sb.push_back(s);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({gnt, dout, dout_valid} !== {e.gnt, e.dout, e.dv})
        begin n_fail++; $display("FAIL lock: gnt=%b dout=%h dv=%b required gnt=%b dout=%h dv=%b", gnt, dout, dout_valid, e.gnt, e.dout, e.dv); end
    end
    lock_i = 1'b0;
  endtask
`endif

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    lock_i = 1'b0;
    din    = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_reset_mid_busy();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
